lifo_v2: RTL and testbench

//   Parametrised successor to the 8-deep stack buffer. Word LIFO with any depth
//   (not only 2**N) and a full-width occupancy count. Supports simultaneous

---
 rtl/lifo_v2_pkg.sv | 7 +
 rtl/lifo_v2_if.sv | 30 +++
 rtl/lifo_v2_ram.sv | 22 ++
 rtl/lifo_v2.sv | 82 ++++++++
 tb/tb_lifo_v2.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/lifo_v2_pkg.sv
// lifo_v2_pkg: shared operation encoding and width helper for the lifo_v2 stack
package lifo_pkg;
    typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP, OP_SWAP} lifo_op_t;
    function automatic int lifo_uw(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/lifo_v2_if.sv
// lifo_v2_if: producer/consumer bus of the lifo_v2 stack
//   master: drives data_i, wrreq_i, rdreq_i; observes q_o, flags, usedw_o, ovf_o, udf_o
//   slave : the stack itself
interface lifo_v2_if
    import lifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 8
) ();
    localparam int UW = lifo_uw(DEPTH);
    logic [DWIDTH-1:0] data_i;
    logic              wrreq_i;
    logic              rdreq_i;
    logic [DWIDTH-1:0] q_o;
    logic              empty_o;
    logic              full_o;
    logic              almost_empty_o;
    logic              almost_full_o;
    logic [UW-1:0]     usedw_o;
    logic              ovf_o;
    logic              udf_o;
    modport master (
        output data_i, wrreq_i, rdreq_i,
        input  q_o, empty_o, full_o, almost_empty_o, almost_full_o, usedw_o, ovf_o, udf_o
    );
    modport slave (
        input  data_i, wrreq_i, rdreq_i,
        output q_o, empty_o, full_o, almost_empty_o, almost_full_o, usedw_o, ovf_o, udf_o
    );
endinterface

// File: rtl/lifo_v2_ram.sv
// lifo_v2_ram: DEPTH x DWIDTH storage, one sync write port, two async read ports
//   clk_i, we, waddr, wdata: write port; raddr1/rdata1, raddr2/rdata2: read ports
module lifo_v2_ram #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DWIDTH-1:0] rdata1,
    output logic [DWIDTH-1:0] rdata2
);
    logic [DWIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk_i)
        if (we) mem[waddr] <= wdata;
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
endmodule

// File: rtl/lifo_v2.sv
// lifo_v2: any-depth word stack with swap, thresholds, show-ahead option, ovf/udf pulses
//   clk_i, srst_i (sync, active-high); bus: lifo_v2_if.slave (data/requests in, q/flags/count out)
module lifo_v2
    import lifo_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int DEPTH        = 8,
    parameter bit SHOWAHEAD    = 1'b0,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input logic      clk_i,
    input logic      srst_i,
    lifo_v2_if.slave bus
);
    localparam int UW = lifo_uw(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);
    localparam logic [UW-1:0] AF_U    = UW'(ALMOST_FULL);
    localparam logic [UW-1:0] AE_U    = UW'(ALMOST_EMPTY);
    logic [UW-1:0]     cnt, cnt_n;
    logic [DWIDTH-1:0] q, rd1, rd2;
    logic              empty, full, a_empty, a_full, ovf, udf;
    logic              wr, rd, is_empty, is_full;
    lifo_op_t          op;
    assign wr       = bus.wrreq_i;
    assign rd       = bus.rdreq_i;
    assign is_empty = cnt == '0;
    assign is_full  = cnt == DEPTH_U;
    // a push+pop on an empty stack degrades to a plain push
    always_comb begin
        op    = (wr && rd && !is_empty) ? OP_SWAP :
                (wr && (rd || !is_full)) ? OP_PUSH :
                (rd && !wr && !is_empty) ? OP_POP : OP_IDLE;
        cnt_n = op == OP_PUSH ? cnt + 1'b1 :
                op == OP_POP  ? cnt - 1'b1 : cnt;
    end
    lifo_v2_ram #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_i  (clk_i),
        .we     (op == OP_PUSH || op == OP_SWAP),
        .waddr  (AW'(op == OP_SWAP ? cnt - 1'b1 : cnt)),
        .wdata  (bus.data_i),
        .raddr1 (AW'(cnt - 1'b1)),
        .raddr2 (AW'(cnt - UW'(2))),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );
    // flags come from the next count so they are exact right after the edge
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt     <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            a_empty <= 1'b1;
            a_full  <= 1'b0;
            q       <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            empty   <= cnt_n == '0;
            full    <= cnt_n == DEPTH_U;
            a_empty <= cnt_n < AE_U;
            a_full  <= cnt_n >= AF_U;
            ovf     <= wr && !rd && is_full;
            udf     <= rd && is_empty;
            if (SHOWAHEAD)
                q <= (op == OP_PUSH || op == OP_SWAP) ? bus.data_i :
                     (op == OP_POP && cnt >= UW'(2)) ? rd2 : q;
            else
                q <= (op == OP_POP || op == OP_SWAP) ? rd1 : q;
        end
    end
    assign bus.q_o            = q;
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.almost_empty_o = a_empty;
    assign bus.almost_full_o  = a_full;
    assign bus.usedw_o        = cnt;
    assign bus.ovf_o          = ovf;
    assign bus.udf_o          = udf;
endmodule

// File: tb/tb_lifo_v2.sv
// tb_lifo_v2: four configurations (DEPTH 8/5 x SHOWAHEAD 0/1) driven in lockstep against a stack model
module tb_lifo_v2;
    logic       clk = 1'b0;
    logic       srst, wr, rd;
    logic [7:0] din;
    int         total = 0;
    int         bad = 0;
    always #5 clk = ~clk;

    lifo_v2_if #(.DWIDTH(8), .DEPTH(8)) b0 ();
    lifo_v2_if #(.DWIDTH(8), .DEPTH(8)) b1 ();
    lifo_v2_if #(.DWIDTH(8), .DEPTH(5)) b2 ();
    lifo_v2_if #(.DWIDTH(8), .DEPTH(5)) b3 ();
    assign b0.data_i = din; assign b0.wrreq_i = wr; assign b0.rdreq_i = rd;
    assign b1.data_i = din; assign b1.wrreq_i = wr; assign b1.rdreq_i = rd;
    assign b2.data_i = din; assign b2.wrreq_i = wr; assign b2.rdreq_i = rd;
    assign b3.data_i = din; assign b3.wrreq_i = wr; assign b3.rdreq_i = rd;

    lifo_v2 #(.DWIDTH(8), .DEPTH(8), .SHOWAHEAD(1'b0), .ALMOST_FULL(6), .ALMOST_EMPTY(2))
        u0 (.clk_i(clk), .srst_i(srst), .bus(b0));
    lifo_v2 #(.DWIDTH(8), .DEPTH(8), .SHOWAHEAD(1'b1), .ALMOST_FULL(6), .ALMOST_EMPTY(2))
        u1 (.clk_i(clk), .srst_i(srst), .bus(b1));
    lifo_v2 #(.DWIDTH(8), .DEPTH(5), .SHOWAHEAD(1'b0), .ALMOST_FULL(4), .ALMOST_EMPTY(2))
        u2 (.clk_i(clk), .srst_i(srst), .bus(b2));
    lifo_v2 #(.DWIDTH(8), .DEPTH(5), .SHOWAHEAD(1'b1), .ALMOST_FULL(4), .ALMOST_EMPTY(2))
        u3 (.clk_i(clk), .srst_i(srst), .bus(b3));

    // reference stacks: st[k][0] is the bottom, n[k] entries held
    int         dep [4] = '{8, 8, 5, 5};
    bit         sa  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int         afl [4] = '{6, 6, 4, 4};
    int         ael = 2;
    logic [7:0] st  [4][8];
    int         n   [4];
    logic [7:0] mq  [4];
    logic       movf[4], mudf[4];

    task automatic model();
        for (int k = 0; k < 4; k++) begin
            if (srst) begin
                n[k] = 0; mq[k] = 8'h00; movf[k] = 1'b0; mudf[k] = 1'b0;
            end else begin
                movf[k] = wr && !rd && n[k] == dep[k];
                mudf[k] = rd && n[k] == 0;
                if (wr && rd && n[k] > 0) begin
                    mq[k] = sa[k] ? din : st[k][n[k]-1];
                    st[k][n[k]-1] = din;
                end else if (wr && (rd || n[k] < dep[k])) begin
                    st[k][n[k]] = din;
                    n[k]++;
                    if (sa[k]) mq[k] = din;
                end else if (rd && !wr && n[k] > 0) begin
                    n[k]--;
                    if (!sa[k]) mq[k] = st[k][n[k]];
                    else if (n[k] > 0) mq[k] = st[k][n[k]-1];
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input int k, input logic [7:0] q, input logic e, input logic f,
                            input logic ae, input logic af, input logic [3:0] uw,
                            input logic ov, input logic ud);
        chk($sformatf("i%0d usedw", k), 32'(uw), 32'(n[k]));
        chk($sformatf("i%0d empty", k), 32'(e), 32'(n[k] == 0));
        chk($sformatf("i%0d full", k), 32'(f), 32'(n[k] == dep[k]));
        chk($sformatf("i%0d almost_empty", k), 32'(ae), 32'(n[k] < ael));
        chk($sformatf("i%0d almost_full", k), 32'(af), 32'(n[k] >= afl[k]));
        chk($sformatf("i%0d ovf", k), 32'(ov), 32'(movf[k]));
        chk($sformatf("i%0d udf", k), 32'(ud), 32'(mudf[k]));
        if (!(sa[k] && n[k] == 0)) chk($sformatf("i%0d q", k), 32'(q), 32'(mq[k]));
    endtask

    task automatic check_all();
        chk_inst(0, b0.q_o, b0.empty_o, b0.full_o, b0.almost_empty_o, b0.almost_full_o,
                 4'(b0.usedw_o), b0.ovf_o, b0.udf_o);
        chk_inst(1, b1.q_o, b1.empty_o, b1.full_o, b1.almost_empty_o, b1.almost_full_o,
                 4'(b1.usedw_o), b1.ovf_o, b1.udf_o);
        chk_inst(2, b2.q_o, b2.empty_o, b2.full_o, b2.almost_empty_o, b2.almost_full_o,
                 4'(b2.usedw_o), b2.ovf_o, b2.udf_o);
        chk_inst(3, b3.q_o, b3.empty_o, b3.full_o, b3.almost_empty_o, b3.almost_full_o,
                 4'(b3.usedw_o), b3.ovf_o, b3.udf_o);
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic s);
        wr = w; rd = r; din = d; srst = s;
        @(posedge clk);
        model();
        #1;
        check_all();
    endtask

    initial begin
        srst = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
        for (int k = 0; k < 4; k++) begin
            n[k] = 0; mq[k] = 8'h00; movf[k] = 1'b0; mudf[k] = 1'b0;
        end
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        chk("reset q_o showahead", 32'(b1.q_o), 32'h0);
        chk("reset q_o depth5", 32'(b3.q_o), 32'h0);
        // push three, pop three
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 0, 8'h33, 0);
        chk("t1 showahead top", 32'(b1.q_o), 32'h33);
        step(0, 1, 8'h00, 0);
        chk("t1 pop1", 32'(b0.q_o), 32'h33);
        chk("t1 showahead after pop1", 32'(b1.q_o), 32'h22);
        step(0, 1, 8'h00, 0);
        chk("t1 pop2", 32'(b0.q_o), 32'h22);
        step(0, 1, 8'h00, 0);
        chk("t1 pop3", 32'(b0.q_o), 32'h11);
        chk("t1 empty", 32'(b0.empty_o), 32'h1);
        // fill the depth-5 stack and push past full
        for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h51 + i), 0);
        chk("t2 ovf depth5", 32'(b2.ovf_o), 32'h1);
        chk("t2 usedw depth5", 32'(b2.usedw_o), 32'd5);
        for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 0);
        chk("t2 last pop depth5", 32'(b2.q_o), 32'h51);
        // underflow, then push+pop on empty
        step(0, 1, 8'h00, 0);
        chk("t3 udf", 32'(b0.udf_o), 32'h1);
        step(0, 0, 8'h00, 0);
        step(1, 1, 8'h77, 0);
        chk("t3 push on empty usedw", 32'(b0.usedw_o), 32'd1);
        chk("t3 push on empty udf", 32'(b0.udf_o), 32'h1);
        step(0, 1, 8'h00, 0);
        // swap
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'hA0, 0);
        step(1, 0, 8'hB0, 0);
        step(1, 1, 8'hC0, 0);
        chk("t4 swap q", 32'(b0.q_o), 32'hB0);
        chk("t4 swap usedw", 32'(b0.usedw_o), 32'd2);
        step(0, 1, 8'h00, 0);
        chk("t4 pop after swap", 32'(b0.q_o), 32'hC0);
        step(0, 1, 8'h00, 0);
        chk("t4 pop bottom", 32'(b0.q_o), 32'hA0);
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h80 + i), 0);
        step(1, 1, 8'hEE, 0);
        chk("t4 swap full", 32'(b0.full_o), 32'h1);
        chk("t4 swap full ovf", 32'(b0.ovf_o), 32'h0);
        step(1, 1, 8'hEF, 0);
        chk("t4 swap full q", 32'(b0.q_o), 32'hEE);
        // threshold sweep
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 8'(i), 0);
        for (int i = 0; i < 9; i++) step(0, 1, 8'h00, 0);
        // reset mid-burst
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h90 + i), 0);
        step(1, 1, 8'h99, 1);
        chk("t6 reset usedw", 32'(b0.usedw_o), 32'd0);
        chk("t6 reset q", 32'(b0.q_o), 32'h0);
        step(0, 1, 8'h00, 0);
        chk("t6 udf after reset", 32'(b0.udf_o), 32'h1);
        // random traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 600; i++) begin
            automatic bit fill = ((i / 40) % 2) == 0;
            automatic logic w = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            automatic logic r = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(w, r, 8'($urandom), $urandom_range(0, 99) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
